// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Brief    : Valid/ready request/response bundle between a data-memory
//            initiator (master) and the dmem_responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle data-memory slave: one request at a time, WAIT_CYCLES
//            wait states, byte-enabled word access, held response.
//            Optional build macro DMEM_RESP_ERR_EN enables the misalignment
//            and range checks; without it addresses wrap and rsp_err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    dmem_responder_if.slave         bus,
    output logic                    busy
);

    localparam int c_MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD =
        (WAIT_CYCLES > 0) ? c_CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [ADDR_W-2:0] c_DEPTH = (ADDR_W - 1)'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [31:0]         r_mem [0:DEPTH_WORDS-1];

    logic [ADDR_W-2:0]   w_word_ext;
    logic [c_MEM_AW-1:0] w_mem_idx;
    logic                w_err;

    assign w_word_ext = {1'b0, r_addr[ADDR_W-1:2]};

`ifdef DMEM_RESP_ERR_EN
    assign w_err     = (r_addr[1:0] != 2'b00) || (w_word_ext >= c_DEPTH);
    assign w_mem_idx = c_MEM_AW'(w_word_ext);
`else
    // Out-of-range word indices alias back into the array.
    logic [ADDR_W-2:0]   w_wrapped;
    logic                w_unused_lsbs;
    assign w_wrapped     = w_word_ext % c_DEPTH;
    assign w_mem_idx     = c_MEM_AW'(w_wrapped);
    assign w_err         = 1'b0;
    assign w_unused_lsbs = ^r_addr[1:0];
`endif

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_next_state = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_write <= bus.req_write;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_be    <= bus.req_be;
                        r_cnt   <= c_CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ACCESS: begin
                    r_err   <= w_err;
                    r_rdata <= (!w_err && !r_write) ? r_mem[w_mem_idx] : 32'h0;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_err <= 1'b0;
                    end
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; a reset edge during ACCESS suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && (r_state == S_ACCESS) && r_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder (WAIT_CYCLES=2
//            main instance plus a WAIT_CYCLES=0 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic busy0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(32)) bus ();
    dmem_responder_if #(.ADDR_W(32)) bus0 ();

    dmem_responder #(
        .ADDR_W      (32),
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    dmem_responder #(
        .ADDR_W      (32),
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave),
        .busy  (busy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance, with optional
    // response backpressure of 'hold' cycles.
    task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic er);
        int lat;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_be    = be;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, 3);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_valid", {31'b0, bus.rsp_valid}, 1);
            chk("bp_rdata", bus.rsp_rdata, rd);
            chk("bp_req_ready", {31'b0, bus.req_ready}, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("idle_after_rsp", {29'b0, bus.req_ready, bus.rsp_valid, busy}, 32'b100);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        reset          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'hFFFF_FFFF;
        bus.req_be     = 4'hF;
        bus.rsp_ready  = 1'b0;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b0;
        bus0.req_addr  = 32'h0;
        bus0.req_wdata = 32'h0;
        bus0.req_be    = 4'h0;
        bus0.rsp_ready = 1'b0;

        // Reset held with a request pending
        tick();
        tick();
        chk("rst_req_ready", {31'b0, bus.req_ready}, 1);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_rdata_err", {bus.rsp_rdata[30:0], bus.rsp_err}, 0);
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        tick();
        chk("post_rst_busy", {31'b0, busy}, 0);

        // Store then load
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
        chk("st10_err", {31'b0, er}, 0);
        chk("st10_rdata", rd, 32'h0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("ld10_rdata", rd, 32'hDEADBEEF);
        chk("ld10_err", {31'b0, er}, 0);

        // Byte enables
        xact(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 0, rd, er);
        xact(1'b1, 32'h20, 32'h11223344, 4'b0101, 0, rd, er);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        chk("ld20_be", rd, 32'hAA22CC44);

        // Zero byte-enable store leaves the word untouched
        xact(1'b1, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("be0_err", {31'b0, er}, 0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("be0_ld10", rd, 32'hDEADBEEF);

        // Response backpressure for 5 cycles
        xact(1'b0, 32'h20, 32'h0, 4'h0, 5, rd, er);
        chk("bp_ld20", rd, 32'hAA22CC44);

        // Error / aliasing behaviour
        xact(1'b1, 32'h0, 32'h01020304, 4'hF, 0, rd, er);
`ifdef DMEM_RESP_ERR_EN
        xact(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er);
        chk("mis_err", {31'b0, er}, 1);
        chk("mis_rdata", rd, 32'h0);
        xact(1'b1, 32'h400, 32'h55555555, 4'hF, 0, rd, er);
        chk("oor_err", {31'b0, er}, 1);
        xact(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
        chk("oor_no_write", rd, 32'h01020304);
        chk("oor_ld0_err", {31'b0, er}, 0);
`else
        xact(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er);
        chk("lsb_ignored", rd, 32'hDEADBEEF);
        chk("lsb_err", {31'b0, er}, 0);
        xact(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0, rd, er);
        chk("wrap_err", {31'b0, er}, 0);
        xact(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
        chk("wrap_alias", rd, 32'hCAFEF00D);
`endif

        // Reset during WAIT abandons the store
        xact(1'b1, 32'h30, 32'h0, 4'hF, 0, rd, er);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'h12345678;
        bus.req_be    = 4'hF;
        tick();
        bus.req_valid = 1'b0;
        chk("wait_busy", {31'b0, busy}, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_state", {29'b0, bus.req_ready, bus.rsp_valid, busy}, 32'b100);
        tick();
        tick();
        tick();
        chk("midrst_no_rsp", {31'b0, bus.rsp_valid}, 0);
        xact(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er);
        chk("midrst_ld30", rd, 32'h0);

        // WAIT_CYCLES=0 instance: one-cycle latency, zero-stall handshake
        bus0.req_valid = 1'b1;
        bus0.req_write = 1'b1;
        bus0.req_addr  = 32'h40;
        bus0.req_wdata = 32'h9ABCDEF0;
        bus0.req_be    = 4'hF;
        bus0.rsp_ready = 1'b1;
        tick();
        bus0.req_valid = 1'b0;
        chk("w0_access", {30'b0, bus0.rsp_valid, busy0}, 32'b01);
        tick();
        chk("w0_rsp_valid", {30'b0, bus0.rsp_valid, bus0.rsp_err}, 32'b10);
        tick();
        chk("w0_idle", {30'b0, bus0.req_ready, bus0.rsp_valid}, 32'b10);
        bus0.req_valid = 1'b1;
        bus0.req_write = 1'b0;
        tick();
        bus0.req_valid = 1'b0;
        tick();
        chk("w0_ld40", bus0.rsp_rdata, 32'h9ABCDEF0);
        tick();

        // Reset during ACCESS on the zero-wait instance suppresses the write
        bus0.req_valid = 1'b1;
        bus0.req_write = 1'b1;
        bus0.req_wdata = 32'h0BADF00D;
        tick();
        bus0.req_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("w0_midrst", {30'b0, bus0.rsp_valid, busy0}, 32'b00);
        bus0.req_valid = 1'b1;
        bus0.req_write = 1'b0;
        tick();
        bus0.req_valid = 1'b0;
        tick();
        chk("w0_midrst_ld40", bus0.rsp_rdata, 32'h9ABCDEF0);
        tick();
        bus0.rsp_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory accesses, operated as a slave on a valid/ready request/response handshake.
- Accepts one load or store request at a time, inserts a configurable number of wait states, and performs a byte-enabled word access on an internal array.
- Returns a response (read data plus error flag) that is held until the initiator accepts it.
- Sits behind the EX/MEM stage. Lets the pipeline be exercised against a multi-cycle memory instead of the single-cycle data memory.

Parameters:
ADDR_W, 32, request address width in bits
DEPTH_WORDS, 256, number of 32-bit words in the internal array
WAIT_CYCLES, 2, wait states inserted between request accept and the access cycle (0 allowed)

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables for store; be[0] selects bits 7:0
rsp_valid  output  1  response available
rsp_ready  input  1  initiator accepts the response
rsp_rdata  output  32  load data; 0 for stores and for errored requests
rsp_err  output  1  request was misaligned or out of range
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (reset==0 at an edge):
  - state goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
  - Array contents are not altered.
  - Reset takes priority over all other events, including mid-transaction. A store not yet performed (still in WAIT) is abandoned. An undelivered response is dropped.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid & req_ready, latch write, addr, wdata and be.
  - Load the counter with WAIT_CYCLES-1 and go to WAIT. If WAIT_CYCLES==0, go directly to ACCESS.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle. Move to ACCESS on the edge where counter==0.
  - Input changes are ignored (request is already latched).
- ACCESS (exactly one cycle):
  - Word index = latched addr[ADDR_W-1:2].
  - Error if addr[1:0]!=0 or index>=DEPTH_WORDS.
  - Store without error: write each byte whose be bit is 1; other bytes unchanged.
  - Load without error: rsp_rdata <= array[index].
  - Error case: no array write, rsp_rdata <= 0, rsp_err <= 1.
  - Next state RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until handshake.
  - On an edge with rsp_ready=1: rsp_valid <= 0, rsp_err <= 0, next state IDLE.
  - rsp_ready ignored in all other states.
- Latency: accept at edge 0 puts rsp_valid high after edge WAIT_CYCLES+1. Minimum request-to-request spacing is WAIT_CYCLES+3 cycles, so there is no overlap of transactions.
- Store with be==4'b0000 completes normally with no array change and rsp_err=0.
- A load of an address stored in the previous transaction returns the new data (the write is completed before RESP).
- rsp_ready high while rsp_valid is already high in the acceptance cycle is legal (zero-stall handshake).

Optional Feature:
DMEM_RESP_ERR_EN
- Defined:
  - Misalignment and range checks as above.
  - rsp_err driven from the check.
- Not defined:
  - No checks. addr[1:0] ignored; index = addr[ADDR_W-1:2] modulo DEPTH_WORDS (wrap-around).
  - rsp_err tied to 0.
  - All requests perform the access.

Test Plan:
1. Reset and idle: hold reset=0 for 2 cycles with req_valid=1, then release -> req_ready=1, rsp_valid=0, busy=0, no request accepted during reset.
2. Store then load, WAIT_CYCLES=2:
   - Store addr 0x10, data 0xDEADBEEF, be=4'hF -> rsp_valid rises 3 cycles after accept, rsp_err=0.
   - Load 0x10 -> rsp_rdata=0xDEADBEEF.
3. Byte enables:
   - Store 0xAABBCCDD to 0x20 with be=F.
   - Store 0x11223344 with be=4'b0101.
   - Load -> 0xAA22CC44.
4. Response backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0; raising rsp_ready gives IDLE next cycle.
5. Error (DMEM_RESP_ERR_EN defined):
   - Load 0x13 -> rsp_err=1, rsp_rdata=0.
   - Store to 0x400 (DEPTH_WORDS=256) -> rsp_err=1, array unchanged.
   - Without the macro: 0x400 aliases word 0.
6. Reset mid-operation:
   - Assert reset during WAIT of a store to 0x30 (prior contents 0x0) -> FSM in IDLE, rsp_valid=0.
   - Later load of 0x30 returns 0x0.
   - Repeat with WAIT_CYCLES=0: rsp_valid one cycle after accept.
